ym_pcma_fetch_sched: RTL and testbench



---
 rtl/ym_pcma_fetch_sched.sv | 221 ++++++++++++++++++++++
 tb/tb_ym_pcma_fetch_sched.sv | 303 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ym_pcma_fetch_sched.sv
`default_nettype none
// ============================================================================
// Module   : ym_pcma_fetch_sched
// Brief    : ADPCM-A sample ROM fetch scheduler. It shares the multiplexed
//            SDRAD/SDRA_L/SDRA_U ROM bus round-robin among six channel
//            decoders, keeps a per-channel byte address counter, and raises
//            sticky end-of-sample flags.
// Revision : 1.0 - initial release
// ============================================================================
module ym_pcma_fetch_sched (
  input  logic        PHI_S,
  input  logic        nRESET,
  input  logic [5:0]  KEYON,
  input  logic [5:0]  KEYOFF,
  input  logic [95:0] START_FLAT,
  input  logic [95:0] STOP_FLAT,
  input  logic [5:0]  DREQ,
  input  logic [5:0]  FLAG_CLR,
  output logic [7:0]  FDATA,
  output logic [5:0]  FVALID,
  output logic [5:0]  PLAYING,
  output logic [5:0]  END_FLAG,
  inout  wire  [7:0]  SDRAD,
  output logic [1:0]  SDRA_L,
  output logic [3:0]  SDRA_U,
  output logic        SDRMPX,
  output logic        nSDROE
);

  localparam int NCH = 6;

  // Bus cycle states: grant in IDLE, two multiplexed address phases, read.
  localparam logic [2:0] IDLE = 3'd0;
  localparam logic [2:0] A1   = 3'd1;
  localparam logic [2:0] L1   = 3'd2;
  localparam logic [2:0] A2   = 3'd3;
  localparam logic [2:0] L2   = 3'd4;
  localparam logic [2:0] RD   = 3'd5;
  localparam logic [2:0] CAP  = 3'd6;

  logic [15:0] start_reg [NCH];
  logic [15:0] stop_reg  [NCH];
  logic [23:0] addr      [NCH];

  logic [2:0]  state, state_nxt;
  logic [2:0]  ch, ch_nxt;
  logic [2:0]  rr;
  logic [23:0] a_lat, a_nxt;
  logic        aborted;

  logic [7:0]  sdrad_q, sdrad_d;
  logic        sdrad_oe, sdrad_oe_d;
  logic [1:0]  sdra_l_d;
  logic [3:0]  sdra_u_d;
  logic        sdrmpx_d;
  logic        nsdroe_d;

  logic [5:0]  eligible;
  logic        grant_found;
  logic [2:0]  grant_ch;
  logic        key_hit;
  logic        cap_ok;
  logic        cap_end;

  generate
    for (genvar g = 0; g < NCH; g++) begin : g_unpack
      assign start_reg[g] = START_FLAT[16*g +: 16];
      assign stop_reg[g]  = STOP_FLAT[16*g +: 16];
    end
  endgenerate

  // The scheduler only drives the data pins during the two address phases.
  assign SDRAD = sdrad_oe ? sdrad_q : 8'hzz;

  // Channel index 'off' places after 'base', modulo the channel count.
  function automatic logic [2:0] rr_next(input logic [2:0] base, input int off);
    int s;
    s = int'(base) + off;
    if (s >= NCH) s = s - NCH;
    return s[2:0];
  endfunction

  // A channel that just received its byte is skipped this cycle, since its
  // decoder has not yet had a chance to drop DREQ.
  assign eligible = PLAYING & DREQ & ~FVALID;

  // Round-robin search starting one past the last winner.
  always_comb begin
    grant_found = 1'b0;
    grant_ch    = 3'd0;
    for (int i = 1; i <= NCH; i++) begin
      if (!grant_found && eligible[rr_next(rr, i)]) begin
        grant_found = 1'b1;
        grant_ch    = rr_next(rr, i);
      end
    end
  end

  // Any key event on the in-flight channel invalidates the byte being fetched.
  assign key_hit = KEYON[ch] | KEYOFF[ch];
  assign cap_ok  = (state == CAP) && PLAYING[ch] && !aborted && !key_hit;
  assign cap_end = cap_ok && (a_lat[23:8] == stop_reg[ch]) && (a_lat[7:0] == 8'hFF);

  // Next bus state and the address/channel latched at grant time.
  always_comb begin
    state_nxt = state;
    a_nxt     = a_lat;
    ch_nxt    = ch;
    case (state)
      IDLE: begin
        if (grant_found) begin
          state_nxt = A1;
          a_nxt     = addr[grant_ch];
          ch_nxt    = grant_ch;
        end
      end
      A1:      state_nxt = L1;
      L1:      state_nxt = A2;
      A2:      state_nxt = L2;
      L2:      state_nxt = RD;
      RD:      state_nxt = CAP;
      CAP:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Pin levels for the state being entered, so every bus output is a flop.
  always_comb begin
    sdrad_d    = 8'h00;
    sdrad_oe_d = 1'b0;
    sdra_l_d   = 2'b00;
    sdra_u_d   = 4'h0;
    sdrmpx_d   = 1'b0;
    nsdroe_d   = 1'b1;
    case (state_nxt)
      A1, L1: begin
        sdrad_d    = a_nxt[7:0];
        sdrad_oe_d = 1'b1;
        sdra_l_d   = a_nxt[9:8];
        sdra_u_d   = a_nxt[23:20];
        sdrmpx_d   = (state_nxt == L1);
      end
      A2, L2: begin
        sdrad_d    = a_nxt[17:10];
        sdrad_oe_d = 1'b1;
        sdra_l_d   = a_nxt[19:18];
        sdra_u_d   = a_nxt[23:20];
        sdrmpx_d   = (state_nxt == A2);
      end
      RD, CAP: begin
        sdra_l_d   = a_nxt[19:18];
        sdra_u_d   = a_nxt[23:20];
        nsdroe_d   = 1'b0;
      end
      default: ;
    endcase
  end

  // Bus sequencer, arbitration pointer and abort tracking.
  always_ff @(posedge PHI_S or negedge nRESET) begin
    if (!nRESET) begin
      state    <= IDLE;
      ch       <= 3'd0;
      a_lat    <= 24'h0;
      rr       <= 3'd5;
      aborted  <= 1'b0;
      sdrad_q  <= 8'h00;
      sdrad_oe <= 1'b0;
      SDRA_L   <= 2'b00;
      SDRA_U   <= 4'h0;
      SDRMPX   <= 1'b0;
      nSDROE   <= 1'b1;
    end else begin
      state    <= state_nxt;
      ch       <= ch_nxt;
      a_lat    <= a_nxt;
      sdrad_q  <= sdrad_d;
      sdrad_oe <= sdrad_oe_d;
      SDRA_L   <= sdra_l_d;
      SDRA_U   <= sdra_u_d;
      SDRMPX   <= sdrmpx_d;
      nSDROE   <= nsdroe_d;
      if (state == IDLE) begin
        if (grant_found) rr <= grant_ch;
        aborted <= grant_found && (KEYON[grant_ch] | KEYOFF[grant_ch]);
      end else if (key_hit) begin
        aborted <= 1'b1;
      end
    end
  end

  // Per-channel counters, play state, end flags and byte delivery.
  always_ff @(posedge PHI_S or negedge nRESET) begin
    if (!nRESET) begin
      for (int n = 0; n < NCH; n++) addr[n] <= 24'h0;
      PLAYING  <= 6'h00;
      END_FLAG <= 6'h00;
      FDATA    <= 8'h00;
      FVALID   <= 6'h00;
    end else begin
      FVALID <= 6'h00;
      if (cap_ok) begin
        FDATA      <= SDRAD;
        FVALID[ch] <= 1'b1;
      end
      for (int n = 0; n < NCH; n++) begin
        if (KEYON[n]) begin
          addr[n]    <= {start_reg[n], 8'h00};
          PLAYING[n] <= 1'b1;
        end else begin
          if (KEYOFF[n] || (cap_end && ch == 3'(n))) PLAYING[n] <= 1'b0;
          if (cap_ok && ch == 3'(n)) addr[n] <= a_lat + 24'd1;
        end
        if (cap_end && ch == 3'(n))  END_FLAG[n] <= 1'b1;
        else if (FLAG_CLR[n])        END_FLAG[n] <= 1'b0;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_ym_pcma_fetch_sched.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : tb_ym_pcma_fetch_sched
// Brief    : Directed self-checking bench for ym_pcma_fetch_sched with a
//            small multiplexed-address ROM model on the sample bus.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ym_pcma_fetch_sched;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [5:0]  keyon = '0, keyoff = '0, dreq = '0, flag_clr = '0;
  logic [95:0] start_flat = '0, stop_flat = '0;
  logic [7:0]  fdata;
  logic [5:0]  fvalid, playing, end_flag;
  wire  [7:0]  sdrad;
  logic [1:0]  sdra_l;
  logic [3:0]  sdra_u;
  logic        sdrmpx, nsdroe;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  logic [9:0]  lo_addr = '0;
  logic [23:0] cur_addr = '0;
  logic [23:0] addr_log [$];
  int          fv_ch [$];
  int          fv_cyc [$];
  logic [7:0]  fv_dat [$];
  int          fv_bad = 0;

  ym_pcma_fetch_sched dut (
    .PHI_S(clk), .nRESET(rst_n), .KEYON(keyon), .KEYOFF(keyoff),
    .START_FLAT(start_flat), .STOP_FLAT(stop_flat), .DREQ(dreq),
    .FLAG_CLR(flag_clr), .FDATA(fdata), .FVALID(fvalid), .PLAYING(playing),
    .END_FLAG(end_flag), .SDRAD(sdrad), .SDRA_L(sdra_l), .SDRA_U(sdra_u),
    .SDRMPX(sdrmpx), .nSDROE(nsdroe)
  );

  always #5 clk = ~clk;

  // ROM contents: one marker byte, otherwise a simple address hash.
  function automatic logic [7:0] rom_byte(input logic [23:0] a);
    if (a == 24'hA5C3F7) return 8'h5A;
    return a[7:0] ^ a[15:8] ^ 8'h3C;
  endfunction

  // ROM side: low address latched on SDRMPX rise, high address on its fall.
  always @(posedge sdrmpx) lo_addr = {sdra_l, sdrad};
  always @(negedge sdrmpx) begin
    if (rst_n) begin
      cur_addr = {sdra_u, sdra_l, sdrad, lo_addr};
      addr_log.push_back(cur_addr);
    end
  end
  assign sdrad = (!nsdroe) ? rom_byte(cur_addr) : 8'hzz;

  always @(posedge clk) cyc <= cyc + 1;

  // Record every delivered byte with its channel and cycle.
  always @(negedge clk) begin
    if (rst_n && fvalid != 6'h00) begin
      if ($countones(fvalid) != 1) fv_bad = fv_bad + 1;
      for (int i = 0; i < 6; i++) if (fvalid[i]) fv_ch.push_back(i);
      fv_cyc.push_back(cyc);
      fv_dat.push_back(fdata);
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_logs();
    addr_log.delete();
    fv_ch.delete();
    fv_cyc.delete();
    fv_dat.delete();
  endtask

  int k, errs, act;

  initial begin
    // ---------------- reset values ----------------
    tick(); tick();
    check("rst_mpx", sdrmpx, 1'b0);
    check("rst_oe", nsdroe, 1'b1);
    check("rst_sdrad_z", sdrad === 8'hzz, 1'b1);
    check("rst_l_u", {sdra_l, sdra_u}, 6'h00);
    check("rst_chan", {fdata, fvalid, playing, end_flag}, 26'h0);
    rst_n = 1'b1;
    tick();

    // ---------------- T1: single channel, 256 bytes then end ----------------
    start_flat[15:0] = 16'h0012;
    stop_flat[15:0]  = 16'h0012;
    keyon = 6'h01; dreq = 6'h01;
    tick();
    keyon = 6'h00;
    check("t1_playing", playing, 6'h01);
    k = 0;
    while (!end_flag[0] && k < 2500) begin tick(); k++; end
    check("t1_end_timeout", k < 2500, 1'b1);
    check("t1_last_fvalid", fvalid, 6'h01);
    check("t1_last_fdata", fdata, rom_byte(24'h0012FF));
    check("t1_stopped", {playing, end_flag}, 12'h001);
    tick();
    check("t1_fv_count", fv_ch.size(), 256);
    check("t1_log_count", addr_log.size(), 256);
    errs = 0;
    for (int i = 0; i < addr_log.size(); i++)
      if (addr_log[i] != 24'h001200 + 24'(i)) errs++;
    check("t1_addr_seq", errs, 0);
    dreq = 6'h00;
    clear_logs();

    // ---------------- T2: bus phases at A = 24'hA5C3F7 ----------------
    start_flat[31:16] = 16'hA5C3;
    stop_flat[31:16]  = 16'hA5C3;
    keyon = 6'h02; dreq = 6'h02;
    tick();
    keyon = 6'h00;
    k = 0;
    while (!(sdrmpx == 1'b0 && sdra_u == 4'hA && sdrad === 8'hF7 && nsdroe == 1'b1) && k < 2500) begin
      tick(); k++;
    end
    check("t2_a1_timeout", k < 2500, 1'b1);
    check("t2_a1", {sdrad, 2'b00, sdra_l, sdra_u, 3'b000, sdrmpx}, {8'hF7, 4'h3, 4'hA, 4'h0});
    tick();
    check("t2_l1", {sdrad, 2'b00, sdra_l, sdra_u, 3'b000, sdrmpx}, {8'hF7, 4'h3, 4'hA, 4'h1});
    tick();
    // A[17:10] of A5C3F7 = {A[17:16]=01, A[15:10]=110000} = 8'h70; A[19:18] = 01
    check("t2_a2", {sdrad, 2'b00, sdra_l, sdra_u, 3'b000, sdrmpx}, {8'h70, 4'h1, 4'hA, 4'h1});
    tick();
    check("t2_l2", {sdrad, 2'b00, sdra_l, sdra_u, 3'b000, sdrmpx}, {8'h70, 4'h1, 4'hA, 4'h0});
    tick();
    check("t2_rd", {nsdroe, sdrmpx, sdra_u}, {1'b0, 1'b0, 4'hA});
    tick();
    check("t2_cap", {nsdroe, sdrmpx, sdra_u}, {1'b0, 1'b0, 4'hA});
    check("t2_cap_nofv", fvalid, 6'h00);
    tick();
    check("t2_fvalid", fvalid, 6'h02);
    check("t2_fdata", fdata, 8'h5A);
    check("t2_idle_oe", nsdroe, 1'b1);

    // ---------------- asynchronous reset in the middle of a fetch ----------------
    k = 0;
    while (sdrmpx != 1'b1 && k < 30) begin tick(); k++; end
    check("t2r_l1_timeout", k < 30, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    check("t2r_mpx", sdrmpx, 1'b0);
    check("t2r_oe", nsdroe, 1'b1);
    check("t2r_sdrad_z", sdrad === 8'hzz, 1'b1);
    check("t2r_chan", {fvalid, playing, end_flag}, 18'h0);
    dreq = 6'h00;
    tick();
    #2 rst_n = 1'b1;
    tick();
    clear_logs();

    // ---------------- T3: six channels, round robin from channel 0 ----------------
    for (int n = 0; n < 6; n++) begin
      start_flat[16*n +: 16] = 16'h2000 + 16'(n);
      stop_flat[16*n +: 16]  = 16'hFFF0;
    end
    keyon = 6'h3F; dreq = 6'h3F;
    tick();
    keyon = 6'h00;
    k = 0;
    while (fv_ch.size() < 12 && k < 200) begin tick(); k++; end
    check("t3_timeout", k < 200, 1'b1);
    for (int i = 0; i < 12 && i < fv_ch.size(); i++) begin
      check($sformatf("t3_order%0d", i), fv_ch[i], i % 6);
      check($sformatf("t3_data%0d", i), fv_dat[i],
            rom_byte({16'h2000 + 16'(i % 6), 8'(i / 6)}));
      if (i > 0) check($sformatf("t3_gap%0d", i), fv_cyc[i] - fv_cyc[i-1], 7);
    end
    check("t3_onehot", fv_bad, 0);
    keyoff = 6'h3F; dreq = 6'h00;
    tick();
    keyoff = 6'h00;
    check("t3_keyoff", playing, 6'h00);
    for (int i = 0; i < 10; i++) tick();
    clear_logs();

    // ---------------- T4: KEYOFF during RD of a channel 2 fetch ----------------
    start_flat[47:32] = 16'h0300;
    stop_flat[47:32]  = 16'hFFFF;
    keyon = 6'h04; dreq = 6'h04;
    tick();
    keyon = 6'h00;
    k = 0;
    while (nsdroe != 1'b0 && k < 30) begin tick(); k++; end
    check("t4_rd_timeout", k < 30, 1'b1);
    keyoff = 6'h04;
    tick();
    keyoff = 6'h00;
    check("t4_playing", playing[2], 1'b0);
    check("t4_cap_oe", nsdroe, 1'b0);
    tick();
    check("t4_nofv", fvalid, 6'h00);
    check("t4_idle_bus", {nsdroe, sdrmpx, sdrad === 8'hzz}, 3'b101);
    act = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (sdrmpx || !nsdroe) act++;
    end
    check("t4_bus_quiet", act, 0);
    check("t4_fv_count", fv_ch.size(), 0);
    dreq = 6'h00;
    clear_logs();

    // ---------------- T5: re-KEYON during A2 of a channel 3 fetch ----------------
    start_flat[63:48] = 16'h0550;
    stop_flat[63:48]  = 16'hFFFF;
    keyon = 6'h08; dreq = 6'h08;
    tick();
    keyon = 6'h00;
    k = 0;
    while (sdrmpx != 1'b1 && k < 30) begin tick(); k++; end
    check("t5_l1_timeout", k < 30, 1'b1);
    tick();
    // A = 055000: A[17:10] = 8'h54
    check("t5_in_a2", {sdrmpx, sdrad}, {1'b1, 8'h54});
    start_flat[63:48] = 16'h0100;
    keyon = 6'h08;
    tick();
    keyon = 6'h00;
    tick(); tick(); tick();
    check("t5_discard", fv_ch.size(), 0);
    check("t5_playing", playing[3], 1'b1);
    addr_log.delete();
    k = 0;
    while (fv_ch.size() < 1 && k < 30) begin tick(); k++; end
    check("t5_next_timeout", k < 30, 1'b1);
    if (addr_log.size() > 0) check("t5_next_addr", addr_log[0], 24'h010000);
    else check("t5_next_addr", 32'hFFFFFFFF, 24'h010000);
    if (fv_ch.size() > 0) check("t5_next_ch_data", {fv_ch[0][7:0], fv_dat[0]}, {8'd3, rom_byte(24'h010000)});
    keyoff = 6'h08; dreq = 6'h00;
    tick();
    keyoff = 6'h00;
    for (int i = 0; i < 10; i++) tick();
    clear_logs();

    // ---------------- T6: address wrap and set-over-clear of END_FLAG ----------------
    start_flat[79:64] = 16'hFFFF;
    stop_flat[79:64]  = 16'h0000;
    keyon = 6'h10; dreq = 6'h10;
    tick();
    keyon = 6'h00;
    k = 0;
    while (addr_log.size() < 512 && k < 5000) begin tick(); k++; end
    check("t6_timeout", k < 5000, 1'b1);
    if (addr_log.size() >= 512) begin
      check("t6_first", addr_log[0], 24'hFFFF00);
      check("t6_top", addr_log[255], 24'hFFFFFF);
      check("t6_wrap", addr_log[256], 24'h000000);
      check("t6_last", addr_log[511], 24'h0000FF);
    end
    errs = 0;
    for (int i = 0; i < addr_log.size(); i++)
      if (addr_log[i] != 24'hFFFF00 + 24'(i)) errs++;
    check("t6_addr_seq", errs, 0);
    tick();
    check("t6_rd_playing", {nsdroe, playing[4]}, 2'b01);
    tick();
    flag_clr = 6'h10;
    tick();
    flag_clr = 6'h00;
    check("t6_set_wins", {end_flag[4], playing[4]}, 2'b10);
    check("t6_fvalid", fvalid, 6'h10);
    tick();
    check("t6_fv_count", fv_ch.size(), 512);
    flag_clr = 6'h10;
    tick();
    flag_clr = 6'h00;
    check("t6_cleared", end_flag, 6'h00);
    act = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (sdrmpx || !nsdroe) act++;
    end
    check("t6_bus_quiet", act, 0);
    dreq = 6'h00;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
